// File: rtl/deserializer_if.sv
// Serial-in / word-out bundle for the deserializer; the slave modport is the DUT view.
interface deserializer_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
);
    logic             in_valid;
    logic [LANES-1:0] in_data;
    logic             in_sync;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             overrun;
    logic             parity_err;

    // A beat is taken on every cycle with in_valid=1 (there is no in_ready).
    // The output word transfers on a rising edge where out_valid && out_ready;
    // out_valid/out_data stay stable until that transfer happens.
    modport slave (
        input  in_valid, in_data, in_sync, out_ready,
        output out_valid, out_data, overrun, parity_err
    );

    modport master (
        output in_valid, in_data, in_sync, out_ready,
        input  out_valid, out_data, overrun, parity_err
    );
endinterface

// File: rtl/deserializer.sv
// Assembles LANES-wide serial beats into WIDTH-bit words behind a one-deep output register.
// Define DESERIALIZER_PARITY_EN to add a trailing even-parity beat per word.
module deserializer #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    deserializer_if.slave bus,
    output logic          dbg_state_o
);
    localparam int              BEATS = WIDTH / LANES;
    localparam int              CW    = $clog2(BEATS) + 1;
    localparam logic [CW-1:0]   LAST  = CW'(BEATS - 1);

    typedef enum logic {COLLECT = 1'b0, PARITY = 1'b1} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    beat_idx;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             overrun_q;
    logic             parity_beat;
    logic             data_beat;
    logic             last_beat;
    logic             done;
    logic [WIDTH-1:0] done_word;
`ifdef DESERIALIZER_PARITY_EN
    logic             done_perr;
    logic             perr_q;
`endif

    // in_sync restarts the word: the beat lands in slot 0 of a cleared word.
    always_comb begin
        beat_idx = bus.in_sync ? '0 : cnt_q;
        word_d   = bus.in_sync ? '0 : word_q;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_idx == CW'(k))
                word_d[(MSB_FIRST ? (BEATS - 1 - k) : k) * LANES +: LANES] = bus.in_data;
        end
        parity_beat = bus.in_valid && !bus.in_sync && (state_q == PARITY);
        data_beat   = bus.in_valid && !parity_beat;
        last_beat   = data_beat && (beat_idx == LAST);
`ifdef DESERIALIZER_PARITY_EN
        done      = parity_beat;
        done_word = word_q;
        done_perr = (^word_q) ^ bus.in_data[0];
`else
        done      = last_beat;
        done_word = word_d;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;

            if (data_beat) begin
                word_q  <= word_d;
                cnt_q   <= last_beat ? '0 : beat_idx + 1'b1;
                state_q <= COLLECT;
`ifdef DESERIALIZER_PARITY_EN
                if (last_beat)
                    state_q <= PARITY;
`endif
            end
            if (parity_beat)
                state_q <= COLLECT;

            // A finished word only replaces the output register if it is free or being taken now.
            if (done) begin
                if (!out_valid_q || bus.out_ready) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= done_word;
`ifdef DESERIALIZER_PARITY_EN
                    perr_q      <= done_perr;
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.overrun    = overrun_q;
`ifdef DESERIALIZER_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: one LSB-first 1-lane instance and one MSB-first 2-lane instance.
module tb_deserializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    deserializer_if #(.WIDTH(8), .LANES(1)) bus1 ();
    deserializer_if #(.WIDTH(8), .LANES(2)) bus2 ();
    logic dbg1;
    logic dbg2;

    deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state_o(dbg1));
    deserializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave), .dbg_state_o(dbg2));

    // Entries are {parity_err, out_data}.
    logic [8:0] exp1_q[$];
    logic [8:0] exp2_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset && bus1.out_valid && bus1.out_ready) begin
            if (exp1_q.size() == 0)
                check("dut1 unexpected word", {23'd0, bus1.parity_err, bus1.out_data}, 32'hFFFF_FFFF);
            else
                check("dut1 word", {23'd0, bus1.parity_err, bus1.out_data}, {23'd0, exp1_q.pop_front()});
        end
        if (!reset && bus2.out_valid && bus2.out_ready) begin
            if (exp2_q.size() == 0)
                check("dut2 unexpected word", {23'd0, bus2.parity_err, bus2.out_data}, 32'hFFFF_FFFF);
            else
                check("dut2 word", {23'd0, bus2.parity_err, bus2.out_data}, {23'd0, exp2_q.pop_front()});
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat1(input logic d, input logic s);
        bus1.in_valid = 1'b1;
        bus1.in_data  = d;
        bus1.in_sync  = s;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus1.in_sync  = 1'b0;
    endtask

    task automatic beat2(input logic [1:0] d, input logic s);
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        bus2.in_sync  = s;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        bus2.in_sync  = 1'b0;
    endtask

    // LSB-first word on dut1, optional gap between beats, with a correct parity beat when enabled.
    task automatic send_word1(input logic [7:0] w, input int gap, input logic sync0);
        for (int i = 0; i < 8; i++) begin
            beat1(w[i], (i == 0) ? sync0 : 1'b0);
            if (gap > 0 && i < 7) idle(gap);
        end
`ifdef DESERIALIZER_PARITY_EN
        beat1(^w, 1'b0);
`endif
    endtask

    logic       t1_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] t2_beats[4] = '{2'b10, 2'b11, 2'b00, 2'b01};

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset          = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.in_sync   = 1'b0;
        bus1.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.in_sync   = 1'b0;
        bus2.out_ready = 1'b1;
        #2;
        check("reset out_valid", bus1.out_valid, 0);
        check("reset out_data", bus1.out_data, 0);
        check("reset overrun", bus1.overrun, 0);
        check("reset parity_err", bus1.parity_err, 0);
        check("reset state", dbg1, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Serial bits 1,0,1,1,0,0,1,0 LSB first -> 8'h4D, valid one cycle after the last beat.
        exp1_q.push_back(9'h04D);
        for (int i = 0; i < 8; i++) beat1(t1_bits[i], 1'b0);
`ifdef DESERIALIZER_PARITY_EN
        beat1(1'b0, 1'b0);
`endif
        check("t1 out_valid", bus1.out_valid, 1);
        check("t1 out_data", bus1.out_data, 32'h4D);
        idle(1);
        check("t1 out_valid drop", bus1.out_valid, 0);

        // Two lanes, MSB first: 10,11,00,01 -> 8'hB1.
        exp2_q.push_back(9'h0B1);
        for (int i = 0; i < 4; i++) beat2(t2_beats[i], 1'b0);
`ifdef DESERIALIZER_PARITY_EN
        beat2(2'b00, 1'b0);
`endif
        check("t2 out_valid", bus2.out_valid, 1);
        check("t2 out_data", bus2.out_data, 32'hB1);
        idle(2);

        // Overrun: A5 held with out_ready low, 3C dropped.
        bus1.out_ready = 1'b0;
        exp1_q.push_back(9'h0A5);
        send_word1(8'hA5, 0, 1'b0);
        check("t3 first valid", bus1.out_valid, 1);
        send_word1(8'h3C, 0, 1'b0);
        check("t3 overrun pulse", bus1.overrun, 1);
        check("t3 data kept", bus1.out_data, 32'hA5);
        idle(1);
        check("t3 overrun clear", bus1.overrun, 0);
        check("t3 data still kept", bus1.out_data, 32'hA5);
        bus1.out_ready = 1'b1;
        idle(1);
        check("t3 valid drop", bus1.out_valid, 0);

        // Partial word discarded by in_sync, then the same word with 5-cycle gaps.
        beat1(1'b1, 1'b0);
        beat1(1'b1, 1'b0);
        beat1(1'b1, 1'b0);
        exp1_q.push_back(9'h096);
        send_word1(8'h96, 0, 1'b1);
        idle(2);
        beat1(1'b1, 1'b0);
        exp1_q.push_back(9'h096);
        send_word1(8'h96, 5, 1'b1);
        idle(2);

        // Reset with a pending word and a 5-beat partial word.
        bus1.out_ready = 1'b0;
        send_word1(8'h5A, 0, 1'b0);
        check("t5 pending valid", bus1.out_valid, 1);
        for (int i = 0; i < 5; i++) beat1(i[0], 1'b0);
        reset = 1'b1;
        #2;
        check("t5 reset out_valid", bus1.out_valid, 0);
        check("t5 reset out_data", bus1.out_data, 0);
        check("t5 reset overrun", bus1.overrun, 0);
        check("t5 reset parity_err", bus1.parity_err, 0);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus1.out_ready = 1'b1;
        idle(1);
        exp1_q.push_back(9'h0C3);
        send_word1(8'hC3, 0, 1'b0);
        check("t5 after reset data", bus1.out_data, 32'hC3);
        idle(2);

`ifdef DESERIALIZER_PARITY_EN
        // 8'h07 has odd weight: parity beat 1 is correct, 0 is an error.
        exp1_q.push_back(9'h007);
        for (int i = 0; i < 8; i++) beat1(i < 3, 1'b0);
        beat1(1'b1, 1'b0);
        exp1_q.push_back(9'h107);
        for (int i = 0; i < 8; i++) beat1(i < 3, 1'b0);
        beat1(1'b0, 1'b0);
        idle(2);
`endif

        for (int i = 0; i < 50 && (exp1_q.size() != 0 || exp2_q.size() != 0); i++)
            @(posedge clk);
        #1;
        check("dut1 queue drained", exp1_q.size(), 0);
        check("dut2 queue drained", exp2_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
